// File: rtl/syscall_console_pkg.sv
// Shared constants for the syscall console: service codes, FSM state
// encoding and byte helpers used by the top and the decimal divider.
package syscall_console_pkg;

  // MIPS/SPIM service codes carried in $v0
  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  // A 32-bit signed magnitude never needs more than ten decimal digits
  localparam int DIGIT_SLOTS = 10;
  // The restoring divider retires one quotient bit per cycle
  localparam int DIV_STEPS   = 32;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CHAR  = 4'd1,
    S_FETCH = 4'd2,
    S_WAIT  = 4'd3,
    S_EMIT  = 4'd4,
    S_CONV  = 4'd5,
    S_DIGIT = 4'd6,
    S_DONE  = 4'd7,
    S_HALT  = 4'd8
  } consoleState;

  // Memory words are big-endian: lane 0 is the most significant byte
  function automatic logic [7:0] laneByte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  function automatic logic [7:0] asciiDigit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

endpackage

// File: rtl/syscall_console_udiv10_seq.sv
// udiv10_seq: 32-bit unsigned divide-by-ten, restoring, one bit per cycle.
// Pulse start with the dividend; done pulses once 32 cycles later with the
// quotient and 4-bit remainder held until the next start.
// Only built when SYSCALL_PRINT_INT_EN is defined.
`ifdef SYSCALL_PRINT_INT_EN
module udiv10_seq
  import syscall_console_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] dividend,
  output logic        done,
  output logic [31:0] quotient,
  output logic [3:0]  remainder
);

  logic [31:0] shiftReg;   // dividend bits shift out, quotient bits shift in
  logic [3:0]  remReg;
  logic [5:0]  stepCnt;
  logic        running;
  logic        doneReg;
  logic [4:0]  trial;
  logic [4:0]  trialSub;

  // Partial remainder with the next dividend bit appended; always < 20
  always_comb begin
    trial    = {remReg, shiftReg[31]};
    trialSub = trial - 5'd10;
  end

  // One restoring step per cycle while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg <= '0;
      remReg   <= '0;
      stepCnt  <= '0;
      running  <= 1'b0;
      doneReg  <= 1'b0;
    end else if (start) begin
      shiftReg <= dividend;
      remReg   <= '0;
      stepCnt  <= '0;
      running  <= 1'b1;
      doneReg  <= 1'b0;
    end else if (running) begin
      if (trial >= 5'd10) begin
        remReg   <= trialSub[3:0];
        shiftReg <= {shiftReg[30:0], 1'b1};
      end else begin
        remReg   <= trial[3:0];
        shiftReg <= {shiftReg[30:0], 1'b0};
      end
      stepCnt <= stepCnt + 6'd1;
      if (stepCnt == 6'(DIV_STEPS - 1)) begin
        running <= 1'b0;
        doneReg <= 1'b1;
      end
    end else begin
      doneReg <= 1'b0;
    end
  end

  assign done      = doneReg;
  assign quotient  = shiftReg;
  assign remainder = remReg;

endmodule
`endif

// File: rtl/syscall_console.sv
// syscall_console: services MIPS syscalls (print_char, print_string, exit and,
// optionally, print_int) by stalling the core and streaming bytes out of a
// valid/ready console port. Strings are read through a second data-memory
// read port with one cycle of latency.
// Build option: define SYSCALL_PRINT_INT_EN to add signed decimal print_int
// (v0=1); without it v0=1 is reported as unsupported.
module syscall_console #(
  parameter int MAX_STR_LEN = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sys_req,
  input  logic [31:0]       sys_v0,
  input  logic [31:0]       sys_a0,
  output logic              sys_busy,
  output logic              sys_done,
  output logic              sys_err,
  output logic              halt,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready
);
  import syscall_console_pkg::*;

  localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

  consoleState       state;
  logic [ADDR_W-1:0] ptr;          // byte address of the current string char
  logic [CNT_W-1:0]  strCnt;       // chars emitted so far in this string
  logic [31:0]       wordReg;      // last word fetched for the string
  logic              charValidReg;
  logic [7:0]        charDataReg;
  logic              memRdReg;
  logic [ADDR_W-1:0] memAddrReg;
  logic              sysDoneReg;
  logic              sysErrReg;
  logic              haltReg;

  logic [ADDR_W-1:0] nextPtr;
  logic [CNT_W-1:0]  cntInc;
  logic [7:0]        fetchByte;    // byte at ptr within the word arriving now
  logic [7:0]        nextByte;     // byte at ptr+1 within the held word

`ifdef SYSCALL_PRINT_INT_EN
  logic        divStart;
  logic [31:0] divDividend;
  logic        divDone;
  logic [31:0] divQuot;
  logic [3:0]  divRem;
  logic        isNeg;
  logic [3:0]  nDigits;            // digits stored so far (LSD at slot 0)
  logic [3:0]  digIdx;             // next slot to print, counting down
  logic [3:0]  digLeft;            // digits still to print after the current char
  logic [3:0]  digitBuf [DIGIT_SLOTS];

  udiv10_seq divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (divStart),
    .dividend  (divDividend),
    .done      (divDone),
    .quotient  (divQuot),
    .remainder (divRem)
  );
`endif

  // String-walk helpers: lookahead pointer, count and bytes
  always_comb begin
    nextPtr   = ptr + ADDR_W'(1);
    cntInc    = strCnt + CNT_W'(1);
    fetchByte = laneByte(mem_rdata, ptr[1:0]);
    nextByte  = laneByte(wordReg, nextPtr[1:0]);
  end

  // Service FSM; every console/memory/handshake output is a register here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ptr          <= '0;
      strCnt       <= '0;
      wordReg      <= '0;
      charValidReg <= 1'b0;
      charDataReg  <= '0;
      memRdReg     <= 1'b0;
      memAddrReg   <= '0;
      sysDoneReg   <= 1'b0;
      sysErrReg    <= 1'b0;
      haltReg      <= 1'b0;
`ifdef SYSCALL_PRINT_INT_EN
      divStart     <= 1'b0;
      divDividend  <= '0;
      isNeg        <= 1'b0;
      nDigits      <= '0;
      digIdx       <= '0;
      digLeft      <= '0;
      for (int i = 0; i < DIGIT_SLOTS; i++) digitBuf[i] <= '0;
`endif
    end else begin
      // One-cycle strobes default low
      sysDoneReg <= 1'b0;
      sysErrReg  <= 1'b0;
      memRdReg   <= 1'b0;
`ifdef SYSCALL_PRINT_INT_EN
      divStart   <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (sys_req) begin
            case (sys_v0)
              SYS_PRINT_CHAR: begin
                charDataReg  <= sys_a0[7:0];
                charValidReg <= 1'b1;
                state        <= S_CHAR;
              end
              SYS_PRINT_STR: begin
                ptr        <= sys_a0[ADDR_W-1:0];
                strCnt     <= '0;
                memRdReg   <= 1'b1;
                memAddrReg <= {sys_a0[ADDR_W-1:2], 2'b00};
                state      <= S_FETCH;
              end
              SYS_EXIT: begin
                haltReg <= 1'b1;
                state   <= S_HALT;
              end
              SYS_PRINT_INT: begin
`ifdef SYSCALL_PRINT_INT_EN
                // Divide the magnitude; 0x80000000 negates to itself, which
                // is the correct unsigned magnitude
                isNeg       <= sys_a0[31];
                divDividend <= sys_a0[31] ? (~sys_a0 + 32'd1) : sys_a0;
                divStart    <= 1'b1;
                nDigits     <= '0;
                state       <= S_CONV;
`else
                sysDoneReg <= 1'b1;
                sysErrReg  <= 1'b1;
                state      <= S_DONE;
`endif
              end
              default: begin
                sysDoneReg <= 1'b1;
                sysErrReg  <= 1'b1;
                state      <= S_DONE;
              end
            endcase
          end
        end

        S_CHAR: begin
          if (char_ready) begin
            charValidReg <= 1'b0;
            sysDoneReg   <= 1'b1;
            state        <= S_DONE;
          end
        end

        S_FETCH: state <= S_WAIT;

        S_WAIT: begin
          wordReg <= mem_rdata;
          if (fetchByte == 8'h00) begin
            sysDoneReg <= 1'b1;
            state      <= S_DONE;
          end else begin
            charDataReg  <= fetchByte;
            charValidReg <= 1'b1;
            state        <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (char_ready) begin
            ptr    <= nextPtr;
            strCnt <= cntInc;
            if (cntInc == CNT_W'(MAX_STR_LEN)) begin
              charValidReg <= 1'b0;
              sysDoneReg   <= 1'b1;
              sysErrReg    <= 1'b1;
              state        <= S_DONE;
            end else if (ptr[1:0] == 2'b11) begin
              charValidReg <= 1'b0;
              memRdReg     <= 1'b1;
              memAddrReg   <= {nextPtr[ADDR_W-1:2], 2'b00};
              state        <= S_FETCH;
            end else if (nextByte == 8'h00) begin
              charValidReg <= 1'b0;
              sysDoneReg   <= 1'b1;
              state        <= S_DONE;
            end else begin
              charDataReg <= nextByte;
            end
          end
        end

`ifdef SYSCALL_PRINT_INT_EN
        S_CONV: begin
          if (divDone) begin
            digitBuf[nDigits] <= divRem;
            nDigits           <= nDigits + 4'd1;
            if (divQuot == 32'd0) begin
              // divRem is the MSD; it is printed straight from the divider
              // unless a sign goes first
              charValidReg <= 1'b1;
              state        <= S_DIGIT;
              if (isNeg) begin
                charDataReg <= 8'h2D;
                digIdx      <= nDigits;
                digLeft     <= nDigits + 4'd1;
              end else begin
                charDataReg <= asciiDigit(divRem);
                digIdx      <= nDigits - 4'd1;
                digLeft     <= nDigits;
              end
            end else begin
              divDividend <= divQuot;
              divStart    <= 1'b1;
            end
          end
        end

        S_DIGIT: begin
          if (char_ready) begin
            if (digLeft == 4'd0) begin
              charValidReg <= 1'b0;
              sysDoneReg   <= 1'b1;
              state        <= S_DONE;
            end else begin
              charDataReg <= asciiDigit(digitBuf[digIdx]);
              digIdx      <= digIdx - 4'd1;
              digLeft     <= digLeft - 4'd1;
            end
          end
        end
`endif

        S_DONE: state <= S_IDLE;

        S_HALT: state <= S_HALT;

        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall the core from the syscall cycle until DONE, and forever once halted
  assign sys_busy   = ((state == S_IDLE) && sys_req) ||
                      ((state != S_IDLE) && (state != S_DONE));
  assign sys_done   = sysDoneReg;
  assign sys_err    = sysErrReg;
  assign halt       = haltReg;
  assign mem_rd     = memRdReg;
  assign mem_addr   = memAddrReg;
  assign char_valid = charValidReg;
  assign char_data  = charDataReg;

endmodule
